// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forwarding unit.
//   fwd_sel_t   : EX operand mux select codes.
//   mdu_state_e : MDU scoreboard FSM states.
//   REG_ADDR_W_DEFAULT : default register index width.
package hazard_forward_unit_pkg;

  localparam int unsigned REG_ADDR_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_MDU   = 2'b11
  } fwd_sel_t;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone,
    StWb
  } mdu_state_e;

endpackage

// File: rtl/hazard_forward_unit_fwd_select.sv
// Per-operand forwarding priority selector (purely combinational).
// Ports:
//   rs_i                 : source register of the operand in EX.
//   rd_ex_mem_i, ex_mem_regwrite_i : EX/MEM destination and write enable.
//   rd_mem_wb_i, mem_wb_regwrite_i : MEM/WB destination and write enable.
//   mdu_valid_i, mdu_rd_i : MDU result valid this cycle and its destination.
//   fwd_o                : selected source, EX/MEM > MEM/WB > MDU > regfile.
module hazard_forward_unit_fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [REG_ADDR_W-1:0] rd_ex_mem_i,
  input  logic                  ex_mem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] rd_mem_wb_i,
  input  logic                  mem_wb_regwrite_i,
  input  logic                  mdu_valid_i,
  input  logic [REG_ADDR_W-1:0] mdu_rd_i,
  output fwd_sel_t              fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (ex_mem_regwrite_i && (rd_ex_mem_i != '0) && (rd_ex_mem_i == rs_i)) begin
      fwd_o = FWD_EXMEM;
    end else if (mem_wb_regwrite_i && (rd_mem_wb_i != '0) && (rd_mem_wb_i == rs_i)) begin
      fwd_o = FWD_MEMWB;
    end else if (mdu_valid_i && (mdu_rd_i == rs_i)) begin
      // mdu_rd is never x0 while a result is valid, so no zero check needed.
      fwd_o = FWD_MDU;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage forwarding, load-use stall/bubble generation and a scoreboard for one
// multi-cycle mul/div unit (MDU).
// Build option: define MDU_FWD_EN to forward the MDU result (code 11) in the DONE
// cycle; otherwise dependent instructions stall through DONE plus a WB cycle.
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset.
//   rs1_id_i, rs2_id_i, mdu_op_id_i : instruction in ID.
//   rs1_id_ex_i, rs2_id_ex_i, rd_id_ex_i, id_ex_memread_i, id_ex_regwrite_i : ID/EX.
//   mdu_issue_i            : MDU op in EX starts now, destination rd_id_ex_i.
//   rd_ex_mem_i, ex_mem_regwrite_i, rd_mem_wb_i, mem_wb_regwrite_i : later stages.
//   fwd_a_o, fwd_b_o       : EX operand selects.
//   stall_o, flush_id_ex_o : hold PC/IF-ID, bubble ID/EX.
//   mdu_busy_o, mdu_done_o, mdu_rd_o : MDU scoreboard status.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int unsigned MDU_LAT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] rs1_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_id_i,
  input  logic                  mdu_op_id_i,
  input  logic [REG_ADDR_W-1:0] rs1_id_ex_i,
  input  logic [REG_ADDR_W-1:0] rs2_id_ex_i,
  input  logic [REG_ADDR_W-1:0] rd_id_ex_i,
  input  logic                  id_ex_memread_i,
  input  logic                  id_ex_regwrite_i,
  input  logic                  mdu_issue_i,
  input  logic [REG_ADDR_W-1:0] rd_ex_mem_i,
  input  logic                  ex_mem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] rd_mem_wb_i,
  input  logic                  mem_wb_regwrite_i,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  stall_o,
  output logic                  flush_id_ex_o,
  output logic                  mdu_busy_o,
  output logic                  mdu_done_o,
  output logic [REG_ADDR_W-1:0] mdu_rd_o
);

  localparam int unsigned CNT_W = $clog2(MDU_LAT);

  mdu_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] mdu_rd_q, mdu_rd_d;

  fwd_sel_t fwd_a, fwd_b;
  logic     mdu_fwd_valid;
  logic     load_use, mdu_dep, mdu_hazard;

  // Load-use only needs memread; regwrite is kept on the interface for integrators.
  logic unused_id_ex_regwrite;
  assign unused_id_ex_regwrite = id_ex_regwrite_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mdu_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mdu_rd_q <= mdu_rd_d;
    end
  end

  // Issues arriving outside IDLE are ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mdu_rd_d = mdu_rd_q;
    unique case (state_q)
      StIdle: begin
        if (mdu_issue_i && (rd_id_ex_i != '0)) begin
          state_d  = StBusy;
          cnt_d    = CNT_W'(MDU_LAT - 1);
          mdu_rd_d = rd_id_ex_i;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
`ifdef MDU_FWD_EN
      StDone:  state_d = StIdle;
`else
      StDone:  state_d = StWb;
`endif
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef MDU_FWD_EN
  assign mdu_fwd_valid = (state_q == StDone);
`else
  assign mdu_fwd_valid = 1'b0;
`endif

  hazard_forward_unit_fwd_select #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_a (
    .rs_i              (rs1_id_ex_i),
    .rd_ex_mem_i       (rd_ex_mem_i),
    .ex_mem_regwrite_i (ex_mem_regwrite_i),
    .rd_mem_wb_i       (rd_mem_wb_i),
    .mem_wb_regwrite_i (mem_wb_regwrite_i),
    .mdu_valid_i       (mdu_fwd_valid),
    .mdu_rd_i          (mdu_rd_q),
    .fwd_o             (fwd_a)
  );

  hazard_forward_unit_fwd_select #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_b (
    .rs_i              (rs2_id_ex_i),
    .rd_ex_mem_i       (rd_ex_mem_i),
    .ex_mem_regwrite_i (ex_mem_regwrite_i),
    .rd_mem_wb_i       (rd_mem_wb_i),
    .mem_wb_regwrite_i (mem_wb_regwrite_i),
    .mdu_valid_i       (mdu_fwd_valid),
    .mdu_rd_i          (mdu_rd_q),
    .fwd_o             (fwd_b)
  );

  assign load_use = id_ex_memread_i && (rd_id_ex_i != '0) &&
                    ((rd_id_ex_i == rs1_id_i) || (rd_id_ex_i == rs2_id_i));

  assign mdu_dep = (rs1_id_i == mdu_rd_q) || (rs2_id_i == mdu_rd_q);

  // Structural hazard holds only in BUSY; the data hazard is released in DONE when
  // the result can be forwarded, otherwise held until the regfile write lands.
  always_comb begin
    mdu_hazard = 1'b0;
    unique case (state_q)
      StBusy:  mdu_hazard = mdu_dep || mdu_op_id_i;
`ifndef MDU_FWD_EN
      StDone,
      StWb:    mdu_hazard = mdu_dep;
`endif
      default: mdu_hazard = 1'b0;
    endcase
  end

  // Combinational outputs are forced idle while reset is asserted.
  assign fwd_a_o       = rst_i ? FWD_RF : fwd_a;
  assign fwd_b_o       = rst_i ? FWD_RF : fwd_b;
  assign stall_o       = !rst_i && (load_use || mdu_hazard);
  assign flush_id_ex_o = stall_o;

  assign mdu_busy_o = (state_q != StIdle);
  assign mdu_done_o = (state_q == StDone);
  assign mdu_rd_o   = mdu_rd_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: expected outputs are queued as each
// cycle's stimulus is applied and compared on the following falling edge.
module tb_hazard_forward_unit;

`ifdef MDU_FWD_EN
  localparam bit FwdEn = 1'b1;
`else
  localparam bit FwdEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1_id = '0, rs2_id = '0, rs1_id_ex = '0, rs2_id_ex = '0, rd_id_ex = '0;
  logic [4:0] rd_ex_mem = '0, rd_mem_wb = '0;
  logic       mdu_op_id = 1'b0, id_ex_memread = 1'b0, id_ex_regwrite = 1'b0;
  logic       mdu_issue = 1'b0, ex_mem_regwrite = 1'b0, mem_wb_regwrite = 1'b0;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, flush_id_ex, mdu_busy, mdu_done;
  logic [4:0] mdu_rd;

  typedef struct {
    string      tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       busy;
    logic       done;
    logic [4:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  hazard_forward_unit #(
    .REG_ADDR_W(5),
    .MDU_LAT   (8)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .rs1_id_i          (rs1_id),
    .rs2_id_i          (rs2_id),
    .mdu_op_id_i       (mdu_op_id),
    .rs1_id_ex_i       (rs1_id_ex),
    .rs2_id_ex_i       (rs2_id_ex),
    .rd_id_ex_i        (rd_id_ex),
    .id_ex_memread_i   (id_ex_memread),
    .id_ex_regwrite_i  (id_ex_regwrite),
    .mdu_issue_i       (mdu_issue),
    .rd_ex_mem_i       (rd_ex_mem),
    .ex_mem_regwrite_i (ex_mem_regwrite),
    .rd_mem_wb_i       (rd_mem_wb),
    .mem_wb_regwrite_i (mem_wb_regwrite),
    .fwd_a_o           (fwd_a),
    .fwd_b_o           (fwd_b),
    .stall_o           (stall),
    .flush_id_ex_o     (flush_id_ex),
    .mdu_busy_o        (mdu_busy),
    .mdu_done_o        (mdu_done),
    .mdu_rd_o          (mdu_rd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                          input logic st, input logic busy, input logic done,
                          input logic [4:0] rd);
    exp_t e;
    e.tag = tag; e.fa = fa; e.fb = fb; e.st = st; e.busy = busy; e.done = done; e.rd = rd;
    sb_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_id = '0; rs2_id = '0; rs1_id_ex = '0; rs2_id_ex = '0; rd_id_ex = '0;
    rd_ex_mem = '0; rd_mem_wb = '0; mdu_op_id = 1'b0; id_ex_memread = 1'b0;
    mdu_issue = 1'b0; ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;
  endtask

  // Plain MDU op with no dependent instruction; prev_rd is mdu_rd before issue.
  task automatic mdu_plain(input logic [4:0] rd, input logic [4:0] prev_rd);
    next_cycle(); mdu_issue = 1'b1; rd_id_ex = rd;
    push_exp("plain_issue", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, prev_rd);
    for (int k = 1; k <= 7; k++) begin
      next_cycle(); mdu_issue = 1'b0; rd_id_ex = '0;
      push_exp("plain_busy", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, rd);
    end
    next_cycle(); push_exp("plain_done", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, rd);
    next_cycle(); push_exp("plain_post", 2'b00, 2'b00, 1'b0, !FwdEn, 1'b0, rd);
    next_cycle(); push_exp("plain_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, rd);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_eq({e.tag, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
      check_eq({e.tag, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
      check_eq({e.tag, ".stall"}, 32'(stall), 32'(e.st));
      check_eq({e.tag, ".flush"}, 32'(flush_id_ex), 32'(e.st));
      check_eq({e.tag, ".busy"}, 32'(mdu_busy), 32'(e.busy));
      check_eq({e.tag, ".done"}, 32'(mdu_done), 32'(e.done));
      check_eq({e.tag, ".mdu_rd"}, 32'(mdu_rd), 32'(e.rd));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    next_cycle(); rst = 1'b0;
    push_exp("post_reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);

    // Forwarding priority.
    next_cycle(); rd_ex_mem = 5; rd_mem_wb = 5; rs1_id_ex = 5;
    ex_mem_regwrite = 1'b1; mem_wb_regwrite = 1'b1;
    push_exp("fwd_exmem_wins", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    next_cycle(); ex_mem_regwrite = 1'b0;
    push_exp("fwd_memwb", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    next_cycle(); ex_mem_regwrite = 1'b1; rd_ex_mem = 0; rd_mem_wb = 0; rs1_id_ex = 0;
    push_exp("fwd_x0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);

    // Independent operands.
    next_cycle(); rs1_id_ex = 3; rd_ex_mem = 3; rs2_id_ex = 7; rd_mem_wb = 7;
    push_exp("fwd_indep", 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0);
    next_cycle(); rs1_id_ex = 7; rs2_id_ex = 3;
    push_exp("fwd_swap", 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0);
    next_cycle(); clear_inputs();
    push_exp("fwd_clear", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);

    // Load-use: one cycle, bubble clears memread.
    next_cycle(); id_ex_memread = 1'b1; rd_id_ex = 4; rs2_id = 4;
    push_exp("load_use", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 5'd0);
    next_cycle(); id_ex_memread = 1'b0; rd_id_ex = 0;
    push_exp("load_use_bubble", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    next_cycle(); id_ex_memread = 1'b1; rd_id_ex = 0; rs1_id = 0; rs2_id = 0;
    push_exp("load_use_x0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    next_cycle(); clear_inputs();
    push_exp("idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);

    // MDU latency with a dependent ID instruction and a stray issue while busy.
    next_cycle(); mdu_issue = 1'b1; rd_id_ex = 9;
    push_exp("mdu_issue", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      mdu_issue = (k == 4);
      rd_id_ex  = (k == 4) ? 5'd12 : 5'd0;
      rs1_id    = (k >= 2) ? 5'd9 : 5'd0;
      push_exp("mdu_busy", 2'b00, 2'b00, k >= 2, 1'b1, 1'b0, 5'd9);
    end
    next_cycle(); mdu_issue = 1'b0; rd_id_ex = 0; rs1_id_ex = 9;
    push_exp("mdu_done", FwdEn ? 2'b11 : 2'b00, 2'b00, !FwdEn, 1'b1, 1'b1, 5'd9);
    next_cycle(); rs1_id_ex = 0;
    push_exp("mdu_post", 2'b00, 2'b00, !FwdEn, !FwdEn, 1'b0, 5'd9);
    next_cycle(); rs1_id = 0;
    push_exp("mdu_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd9);

    // Issue to x0 never enters BUSY.
    next_cycle(); mdu_issue = 1'b1; rd_id_ex = 0;
    push_exp("issue_x0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd9);
    next_cycle(); mdu_issue = 1'b0;
    push_exp("issue_x0_next", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd9);

    // Structural MDU hazard, overlapped once with a load-use.
    next_cycle(); mdu_issue = 1'b1; rd_id_ex = 6;
    push_exp("struct_issue", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd9);
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      mdu_issue     = 1'b0;
      mdu_op_id     = 1'b1;
      id_ex_memread = (k == 3);
      rd_id_ex      = (k == 3) ? 5'd4 : 5'd0;
      rs2_id        = (k == 3) ? 5'd4 : 5'd0;
      push_exp("struct_busy", 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 5'd6);
    end
    next_cycle(); id_ex_memread = 1'b0; rd_id_ex = 0; rs2_id = 0;
    push_exp("struct_done", 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 5'd6);
    next_cycle(); push_exp("struct_post", 2'b00, 2'b00, 1'b0, !FwdEn, 1'b0, 5'd6);
    next_cycle(); mdu_op_id = 1'b0;
    push_exp("struct_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd6);

    // Reset mid-operation.
    next_cycle(); mdu_issue = 1'b1; rd_id_ex = 9;
    push_exp("rst_issue", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd6);
    for (int k = 1; k <= 2; k++) begin
      next_cycle(); mdu_issue = 1'b0; rd_id_ex = 0;
      push_exp("rst_busy", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 5'd9);
    end
    next_cycle(); rst = 1'b1;
    rd_ex_mem = 5; ex_mem_regwrite = 1'b1; rs1_id_ex = 5; rs2_id_ex = 5;
    id_ex_memread = 1'b1; rd_id_ex = 4; rs1_id = 4; rs1_id = 9;  rs2_id = 4;
    push_exp("rst_async", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    next_cycle(); push_exp("rst_held", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    next_cycle(); rst = 1'b0; clear_inputs();
    push_exp("rst_release", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    for (int k = 6; k <= 12; k++) begin
      next_cycle(); push_exp("rst_no_done", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0);
    end
    mdu_plain(5'd11, 5'd0);

    repeat (3) next_cycle();
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
